// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable integer clock divider, 50% duty for any N >= 2.
//
// Ports:
//   clk          single clock; both edges are used (posedge state, negedge half-cycle flop)
//   rst          asynchronous active-high reset for every flop
//   en           run request, sampled on posedge clk
//   div_in       candidate divisor
//   div_load     one-cycle strobe capturing div_in
//   div_pending  a loaded divisor is waiting for the next period boundary
//   load_err     one-cycle pulse: a load with div_in < 2 was rejected
//   div_active   divisor governing the current period
//   freq_out     divided clock
//   tick         high for the first clk cycle of every period
module freq_div_prog #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_pending,
    output logic             load_err,
    output logic [WIDTH-1:0] div_active,
    output logic             freq_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEFAULT_DIV);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             running_q, running_d;
    logic             pos_q, pos_d;
    logic             neg_q;
    logic [WIDTH-1:0] div_q, div_d;
    logic             odd_q, odd_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;

    logic             last;
    logic             boundary;

    // Wrap compares against N-1 so cnt never exceeds N-1, even for N = 2^WIDTH-1.
    assign last     = running_q && (cnt_q == (div_q - WIDTH'(1)));
    assign boundary = last || (!running_q && en);

    always_comb begin
        cnt_d      = cnt_q;
        running_d  = running_q;
        pos_d      = pos_q;
        div_d      = div_q;
        odd_d      = odd_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        err_d      = 1'b0;

        // A pending divisor takes over only at a period boundary.
        if (boundary && pend_q) begin
            div_d  = pend_val_q;
            odd_d  = pend_val_q[0];
            pend_d = 1'b0;
        end

        if (!running_q) begin
            if (en) begin
                running_d = 1'b1;
                cnt_d     = '0;
                pos_d     = 1'b1;
            end
        end else if (last) begin
            cnt_d = '0;
            if (en) begin
                // New period starts at cnt=0, and H >= 1 for every legal N.
                pos_d = 1'b1;
            end else begin
                running_d = 1'b0;
                pos_d     = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + WIDTH'(1);
            pos_d = (cnt_q + WIDTH'(1)) < (div_q >> 1);
        end

        // Loads after the apply: a load on the wrap edge stays pending for the next period.
        if (div_load) begin
            if (div_in >= WIDTH'(2)) begin
                pend_val_d = div_in;
                pend_d     = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            running_q  <= 1'b0;
            pos_q      <= 1'b0;
            div_q      <= DefDiv;
            odd_q      <= DefDiv[0];
            pend_val_q <= '0;
            pend_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            running_q  <= running_d;
            pos_q      <= pos_d;
            div_q      <= div_d;
            odd_q      <= odd_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
        end
    end

    // Half-cycle delayed copy of pos_q; stretches the high phase by 0.5 clk for odd N.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    assign freq_out    = pos_q | (neg_q & odd_q);
    assign tick        = running_q & (cnt_q == '0);
    assign div_pending = pend_q;
    assign load_err    = err_q;
    assign div_active  = div_q;

endmodule

// File: tb/tb_freq_div_prog.sv
module tb_freq_div_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       div_pending;
    logic       load_err;
    logic [7:0] div_active;
    logic       freq_out;
    logic       tick;

    freq_div_prog #(
        .WIDTH      (8),
        .DEFAULT_DIV(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .div_load   (div_load),
        .div_pending(div_pending),
        .load_err   (load_err),
        .div_active (div_active),
        .freq_out   (freq_out),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per rising edge of freq_out, describing the interval since the previous rise:
    // divisor at that rise, half-cycles high, ticks seen, posedges elapsed, div_pending on the
    // last posedge before this rise, div_pending at this rise.
    typedef struct packed {
        logic [15:0] div;
        logic [15:0] hi;
        logic [15:0] ticks;
        logic [15:0] gap;
        logic        pp;
        logic        pa;
    } rec_t;

    typedef struct packed {
        logic [7:0] div;
        logic       pend;
    } err_t;

    rec_t rec_q[$];
    err_t err_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic rec_t mk(input int d, input int h, input int t, input int g,
                                input bit pp, input bit pa);
        rec_t r;
        r.div   = 16'(d);
        r.hi    = 16'(h);
        r.ticks = 16'(t);
        r.gap   = 16'(g);
        r.pp    = pp;
        r.pa    = pa;
        return r;
    endfunction

    // Steady period of divisor n: n half-cycles high (2H or 2H+1), one tick, n posedges.
    task automatic exp_per(input int n, input bit pp);
        rec_q.push_back(mk(n, n, 1, n, pp, 1'b0));
    endtask

    task automatic push_err(input logic [7:0] d);
        err_t e;
        e.div  = d;
        e.pend = 1'b0;
        err_q.push_back(e);
    endtask

    task automatic do_load(input logic [7:0] v);
        div_in   = v;
        div_load = 1'b1;
        @(negedge clk);
        div_load = 1'b0;
    endtask

    // Advance to the negedge following the next period start.
    task automatic align();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk);
            if (tick) found = 1'b1;
        end
        if (!found) begin
            n_cmp++;
            n_fail++;
            $display("FAIL align: tick stayed 0 for 600 cycles, required 1");
        end
    endtask

    // Reset-state monitor.
    initial begin
        forever begin
            @(posedge rst);
            #1;
            n_cmp++;
            if ({freq_out, tick, div_pending, load_err, div_active} !== {4'b0000, 8'd5}) begin
                n_fail++;
                $display("FAIL reset: got fo=%b tick=%b pend=%b err=%b div=%0d, want 0 0 0 0 5",
                         freq_out, tick, div_pending, load_err, div_active);
            end
        end
    end

    // Waveform monitor, sampling 1 time unit after every clk edge.
    initial begin
        bit   prev_fo   = 1'b0;
        bit   pend_prev = 1'b0;
        int   gap = 0, hi = 0, ticks = 0, pdiv = 0;
        rec_t got, want;
        err_t eg, ew;
        forever begin
            @(clk);
            #1;
            if (rst) begin
                prev_fo   = 1'b0;
                pend_prev = 1'b0;
                gap = 0; hi = 0; ticks = 0; pdiv = 0;
            end else begin
                if (clk) begin
                    gap++;
                    if (freq_out && !prev_fo) begin
                        got = mk(pdiv, hi, ticks, gap, pend_prev, div_pending);
                        n_cmp++;
                        if (rec_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL period@%0t: unexpected rise div=%0d hi=%0d gap=%0d",
                                     $time, got.div, got.hi, got.gap);
                        end else begin
                            want = rec_q.pop_front();
                            if (got !== want) begin
                                n_fail++;
                                $display({"FAIL period@%0t: got div=%0d hi=%0d ticks=%0d ",
                                          "gap=%0d pp=%0b pa=%0b, want div=%0d hi=%0d ",
                                          "ticks=%0d gap=%0d pp=%0b pa=%0b"},
                                         $time, got.div, got.hi, got.ticks, got.gap, got.pp,
                                         got.pa, want.div, want.hi, want.ticks, want.gap,
                                         want.pp, want.pa);
                            end
                        end
                        pdiv = int'(div_active);
                        hi = 0; ticks = 0; gap = 0;
                    end
                    if (tick) ticks++;
                    if (load_err) begin
                        eg.div  = div_active;
                        eg.pend = div_pending;
                        n_cmp++;
                        if (err_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL load_err@%0t: got pulse, want none", $time);
                        end else begin
                            ew = err_q.pop_front();
                            if (eg !== ew) begin
                                n_fail++;
                                $display("FAIL load_err@%0t: got div=%0d pend=%0b, want %0d %0b",
                                         $time, eg.div, eg.pend, ew.div, ew.pend);
                            end
                        end
                    end
                    pend_prev = div_pending;
                end
                if (freq_out) hi++;
                prev_fo = freq_out;
            end
        end
    end

    initial begin
        rst      = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        div_in   = 8'd0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Default N=5: first rise on the posedge that samples en.
        rec_q.push_back(mk(0, 0, 0, 2, 1'b0, 1'b0));
        @(negedge clk);
        en = 1'b1;
        exp_per(5, 1'b0);
        exp_per(5, 1'b0);
        align();
        align();
        align();

        // Mid-period loads 4, 3, 2, then back to 5; each applies at the next wrap.
        exp_per(5, 1'b1); do_load(8'd4); align();
        exp_per(4, 1'b1); do_load(8'd3); align();
        exp_per(3, 1'b1); do_load(8'd2); align();
        exp_per(2, 1'b0); align();
        exp_per(2, 1'b1); do_load(8'd5); align();

        // Rejected loads.
        exp_per(5, 1'b0);
        push_err(8'd5); do_load(8'd1);
        push_err(8'd5); do_load(8'd0);
        align();

        // Last load wins; a load on the wrap edge defers one period.
        exp_per(5, 1'b1); do_load(8'd6); do_load(8'd7); align();
        rec_q.push_back(mk(7, 7, 1, 7, 1'b0, 1'b1));
        exp_per(7, 1'b1);
        repeat (6) @(negedge clk);
        do_load(8'd6);
        align();
        exp_per(6, 1'b1); do_load(8'd5); align();

        // Graceful stop at cnt=1, restart after idle; then a cancelled stop.
        rec_q.push_back(mk(5, 5, 1, 8, 1'b0, 1'b0));
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        en = 1'b1;
        align();
        exp_per(5, 1'b0);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        align();

        // Maximum divisor, then asynchronous reset mid-high.
        exp_per(5, 1'b1); do_load(8'd255); align();
        exp_per(255, 1'b0); align();
        repeat (50) @(negedge clk);
        #2 rst = 1'b1;
        rec_q.push_back(mk(0, 0, 0, 1, 1'b0, 1'b0));
        @(negedge clk);
        rst = 1'b0;
        exp_per(5, 1'b0);
        align();
        align();
        repeat (3) @(negedge clk);

        n_cmp++;
        if (rec_q.size() != 0) begin
            n_fail++;
            $display("FAIL period_queue: got %0d unmatched, want 0", rec_q.size());
        end
        n_cmp++;
        if (err_q.size() != 0) begin
            n_fail++;
            $display("FAIL err_queue: got %0d unmatched, want 0", err_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
